uart_tx_sched: RTL and testbench

UART transmit scheduler for the execute stage. It owns the transmit ring buffer held in an external simple-dual-port BRAM and accepts bytes from the CPU output port. It drains the buffer into `uart_tx` while honouring the BRAM read latency and the `tx_start`/`tx_busy` handshake. It also arbitrates a one-shot loader handshake byte (0xAA), which has priority over buffered program output.

---
 rtl/uart_tx_sched.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_sched.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: ring-buffered UART transmit scheduler with a one-shot loader byte.
// Bytes pushed by the CPU are written into an external simple-dual-port BRAM
// and drained one at a time into uart_tx through the tx_start/tx_busy handshake.
module uart_tx_sched #(
  parameter int unsigned TX_SIZE  = 10,
  parameter int unsigned READ_LAT = 3
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               boot_req,
  output logic               boot_done,
  input  logic               cpu_wr_valid,
  input  logic [7:0]         cpu_wr_data,
  output logic               cpu_wr_ready,
  output logic [TX_SIZE-1:0] bram_addra,
  output logic [7:0]         bram_dina,
  output logic               bram_wea,
  output logic [TX_SIZE-1:0] bram_addrb,
  input  logic [7:0]         bram_doutb,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  output logic               empty
);

  localparam int unsigned LAT_W     = 3;
  localparam logic [7:0]  BOOT_BYTE = 8'hAA;

  // doutb is valid READ_LAT cycles after the pop decision, so FETCH spans
  // READ_LAT-1 cycles and LAUNCH samples doutb in the cycle it becomes valid;
  // tx_start then rises READ_LAT+1 cycles after the decision.
  localparam bit               NO_FETCH = (READ_LAT <= 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((READ_LAT >= 2) ? (READ_LAT - 2) : 0);

  // The loader byte launches straight out of IDLE, so BOOT needs no encoding.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [TX_SIZE-1:0] top_q, top_d;
  logic [TX_SIZE-1:0] top_c_q, top_c_d;
  logic [TX_SIZE-1:0] bot_q, bot_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [TX_SIZE-1:0] bram_addra_q, bram_addra_d;
  logic [7:0]         bram_dina_q, bram_dina_d;
  logic               bram_wea_q, bram_wea_d;
  logic [TX_SIZE-1:0] bram_addrb_q, bram_addrb_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               boot_done_q, boot_done_d;
  logic               boot_flag_q, boot_flag_d;

  // Buffer status: one slot is kept free to tell full from empty.
  assign cpu_wr_ready = ((top_q + TX_SIZE'(1)) != bot_q);
  assign empty        = (bot_q == top_c_q);

  assign bram_addra = bram_addra_q;
  assign bram_dina  = bram_dina_q;
  assign bram_wea   = bram_wea_q;
  assign bram_addrb = bram_addrb_q;
  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign boot_done  = boot_done_q;

  // Write side: accept a CPU byte into the ring and commit top one cycle later.
  always_comb begin
    top_d        = top_q;
    top_c_d      = top_q;
    bram_addra_d = bram_addra_q;
    bram_dina_d  = bram_dina_q;
    bram_wea_d   = 1'b0;
    if (cpu_wr_valid && cpu_wr_ready) begin
      bram_addra_d = top_q;
      bram_dina_d  = cpu_wr_data;
      bram_wea_d   = 1'b1;
      top_d        = top_q + TX_SIZE'(1);
    end
  end

  // Drain FSM: loader byte first, otherwise fetch from BRAM and hand to uart_tx.
  always_comb begin
    state_d      = state_q;
    bot_d        = bot_q;
    lat_d        = lat_q;
    bram_addrb_d = bram_addrb_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    boot_flag_d  = boot_flag_q;
    boot_done_d  = boot_done_q;
    case (state_q)
      ST_IDLE: begin
        if (boot_req && !boot_done_q && !tx_busy) begin
          tx_data_d   = BOOT_BYTE;
          tx_start_d  = 1'b1;
          boot_flag_d = 1'b1;
          state_d     = ST_WAIT_HI;
        end else if (!tx_busy && (bot_q != top_c_q)) begin
          bram_addrb_d = bot_q;
          bot_d        = bot_q + TX_SIZE'(1);
          lat_d        = '0;
          state_d      = NO_FETCH ? ST_LAUNCH : ST_FETCH;
        end
      end
      ST_FETCH: begin
        lat_d = lat_q + LAT_W'(1);
        if (lat_q == LAT_LAST) begin
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        tx_data_d  = bram_doutb;
        tx_start_d = 1'b1;
        state_d    = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (tx_busy) begin
          state_d = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          if (boot_flag_q) begin
            boot_done_d = 1'b1;
          end
          boot_flag_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      top_q        <= '0;
      top_c_q      <= '0;
      bot_q        <= '0;
      lat_q        <= '0;
      bram_addra_q <= '0;
      bram_dina_q  <= '0;
      bram_wea_q   <= 1'b0;
      bram_addrb_q <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      boot_done_q  <= 1'b0;
      boot_flag_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      top_q        <= top_d;
      top_c_q      <= top_c_d;
      bot_q        <= bot_d;
      lat_q        <= lat_d;
      bram_addra_q <= bram_addra_d;
      bram_dina_q  <= bram_dina_d;
      bram_wea_q   <= bram_wea_d;
      bram_addrb_q <= bram_addrb_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      boot_done_q  <= boot_done_d;
      boot_flag_q  <= boot_flag_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: bench for uart_tx_sched with a BRAM model and a uart_tx model.
module tb_uart_tx_sched;

  localparam int unsigned TXS = 3;
  localparam int unsigned RL  = 3;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           boot_req = 1'b0;
  logic           boot_done;
  logic           cpu_wr_valid = 1'b0;
  logic [7:0]     cpu_wr_data = 8'h00;
  logic           cpu_wr_ready;
  logic [TXS-1:0] bram_addra;
  logic [7:0]     bram_dina;
  logic           bram_wea;
  logic [TXS-1:0] bram_addrb;
  logic [7:0]     bram_doutb;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic           empty;

  always #5 clk = ~clk;

  uart_tx_sched #(.TX_SIZE(TXS), .READ_LAT(RL)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .boot_req     (boot_req),
    .boot_done    (boot_done),
    .cpu_wr_valid (cpu_wr_valid),
    .cpu_wr_data  (cpu_wr_data),
    .cpu_wr_ready (cpu_wr_ready),
    .bram_addra   (bram_addra),
    .bram_dina    (bram_dina),
    .bram_wea     (bram_wea),
    .bram_addrb   (bram_addrb),
    .bram_doutb   (bram_doutb),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .empty        (empty)
  );

  // BRAM: data for the address registered at the pop decision is valid RL cycles after it.
  logic [7:0]     mem   [1 << TXS];
  logic [TXS-1:0] apipe [RL-1];
  always @(posedge clk) begin
    if (bram_wea) mem[bram_addra] <= bram_dina;
    apipe[0] <= bram_addrb;
    for (int i = 1; i < int'(RL) - 1; i++) apipe[i] <= apipe[i-1];
  end
  assign bram_doutb = mem[apipe[RL-2]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: busy rises the cycle after tx_start and stays high for a few cycles.
  logic       model_busy = 1'b0;
  logic       busy_force = 1'b0;
  bit         arm = 1'b0;
  bit         prev_start = 1'b0;
  bit         rand_len = 1'b0;
  int         busy_left = 0;
  int         busy_len = 3;
  int         proto_err = 0;
  logic [7:0] out_q [$];
  int         out_cyc [$];
  assign tx_busy = model_busy | busy_force;

  always @(negedge clk) begin
    if (!rstn) begin
      model_busy = 1'b0;
      busy_left  = 0;
      arm        = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (tx_start && (prev_start || model_busy || arm)) proto_err++;
      if (arm) begin
        model_busy = 1'b1;
        busy_left  = rand_len ? int'($urandom_range(1, 6)) : busy_len;
        arm        = 1'b0;
      end else if (model_busy) begin
        busy_left--;
        if (busy_left <= 0) model_busy = 1'b0;
      end
      if (tx_start) begin
        out_q.push_back(tx_data);
        out_cyc.push_back(cyc);
        arm = 1'b1;
      end
      prev_start = tx_start;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn         = 1'b0;
    cpu_wr_valid = 1'b0;
    cpu_wr_data  = 8'h00;
    boot_req     = 1'b0;
    busy_force   = 1'b0;
    tick();
    tick();
    out_q.delete();
    out_cyc.delete();
    rstn = 1'b1;
  endtask

  task automatic wait_out(input int n, input string name);
    int g = 0;
    while (out_q.size() < n && g < 3000) begin
      tick();
      g++;
    end
    check({name, "_count"}, 32'(out_q.size()), 32'(n));
  endtask

  typedef struct {
    logic           valid;
    logic [7:0]     data;
    logic           exp_ready;
    logic           exp_wea;
    logic [TXS-1:0] exp_addra;
    logic           exp_empty;
  } vec_t;

  vec_t       tbl [9];
  logic [7:0] exp_q [$];
  int         m;
  int         g;
  int         acc;
  int         diff;
  bit         v;

  initial begin
    // Fill-to-full vectors with uart_tx held busy so nothing drains.
    for (int i = 0; i < 7; i++) begin
      tbl[i].valid     = 1'b1;
      tbl[i].data      = 8'(8'h10 + i);
      tbl[i].exp_ready = 1'b1;
      tbl[i].exp_wea   = 1'b1;
      tbl[i].exp_addra = TXS'(i);
      tbl[i].exp_empty = (i == 0);
    end
    tbl[7] = '{valid: 1'b1, data: 8'h99, exp_ready: 1'b0, exp_wea: 1'b0, exp_addra: 3'd6, exp_empty: 1'b0};
    tbl[8] = '{valid: 1'b0, data: 8'h00, exp_ready: 1'b0, exp_wea: 1'b0, exp_addra: 3'd6, exp_empty: 1'b0};

    // Reset state.
    do_reset();
    check("rst_ready", cpu_wr_ready, 1);
    check("rst_empty", empty, 1);
    check("rst_tx_start", tx_start, 0);
    check("rst_boot_done", boot_done, 0);
    check("rst_wea", bram_wea, 0);
    check("rst_addra", bram_addra, 0);
    check("rst_addrb", bram_addrb, 0);
    check("rst_tx_data", tx_data, 0);

    // Loader byte: start one cycle after the decision, sent only once.
    do_reset();
    rand_len = 1'b0;
    busy_len = 3;
    boot_req = 1'b1;
    m = cyc;
    wait_out(1, "boot");
    check("boot_start_cycle", 32'(out_cyc[0]), 32'(m + 1));
    check("boot_data", out_q[0], 8'hAA);
    g = 0;
    while (!boot_done && g < 100) begin tick(); g++; end
    check("boot_done_set", boot_done, 1);
    check("boot_done_after_busy", model_busy, 0);
    repeat (20) tick();
    check("boot_once", 32'(out_q.size()), 1);
    check("boot_done_sticky", boot_done, 1);
    boot_req = 1'b0;

    // Single push: write pulse next cycle, tx_start six cycles after accept.
    do_reset();
    cpu_wr_valid = 1'b1;
    cpu_wr_data  = 8'h41;
    m = cyc;
    tick();
    cpu_wr_valid = 1'b0;
    check("push_wea", bram_wea, 1);
    check("push_addra", bram_addra, 0);
    check("push_dina", bram_dina, 8'h41);
    tick();
    check("push_wea_clear", bram_wea, 0);
    wait_out(1, "push");
    check("push_start_cycle", 32'(out_cyc[0]), 32'(m + 6));
    check("push_data", out_q[0], 8'h41);
    check("push_empty_after", empty, 1);

    // Fill to capacity, drop on full, then drain and push across the wrap.
    do_reset();
    busy_len   = 2;
    busy_force = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 9; i++) begin
      cpu_wr_valid = tbl[i].valid;
      cpu_wr_data  = tbl[i].data;
      check($sformatf("full_ready_%0d", i), cpu_wr_ready, tbl[i].exp_ready);
      if (tbl[i].exp_ready && tbl[i].valid) exp_q.push_back(tbl[i].data);
      tick();
      check($sformatf("full_wea_%0d", i), bram_wea, tbl[i].exp_wea);
      check($sformatf("full_addra_%0d", i), bram_addra, tbl[i].exp_addra);
      check($sformatf("full_empty_%0d", i), empty, tbl[i].exp_empty);
    end
    cpu_wr_valid = 1'b0;
    check("full_no_traffic", 32'(out_q.size()), 0);
    busy_force = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cpu_wr_valid = 1'b1;
      cpu_wr_data  = 8'(8'h30 + k);
      g = 0;
      while (!cpu_wr_ready && g < 500) begin tick(); g++; end
      tick();
      if (k == 0) check("wrap_first_addra", bram_addra, 7);
      exp_q.push_back(8'(8'h30 + k));
    end
    cpu_wr_valid = 1'b0;
    wait_out(17, "wrap");
    for (int i = 0; i < 17; i++) check($sformatf("wrap_byte_%0d", i), out_q[i], exp_q[i]);

    // Loader request while byte 1 is in WAIT_LO goes ahead of bytes 2 and 3.
    do_reset();
    busy_len     = 4;
    cpu_wr_valid = 1'b1;
    cpu_wr_data  = 8'hB1; tick();
    cpu_wr_data  = 8'hB2; tick();
    cpu_wr_data  = 8'hB3; tick();
    cpu_wr_valid = 1'b0;
    g = 0;
    while (!model_busy && g < 100) begin tick(); g++; end
    tick();
    boot_req = 1'b1;
    check("mid_boot_one_out", 32'(out_q.size()), 1);
    wait_out(4, "mid_boot");
    check("mid_boot_b0", out_q[0], 8'hB1);
    check("mid_boot_b1", out_q[1], 8'hAA);
    check("mid_boot_b2", out_q[2], 8'hB2);
    check("mid_boot_b3", out_q[3], 8'hB3);
    g = 0;
    while (!boot_done && g < 100) begin tick(); g++; end
    check("mid_boot_done", boot_done, 1);
    boot_req = 1'b0;

    // Reset while the first of two buffered bytes is in FETCH.
    do_reset();
    busy_len     = 2;
    cpu_wr_valid = 1'b1;
    cpu_wr_data  = 8'hC1; tick();
    cpu_wr_data  = 8'hC2; tick();
    cpu_wr_valid = 1'b0;
    tick();
    rstn = 1'b0;
    tick();
    check("fetch_rst_tx_start", tx_start, 0);
    rstn = 1'b1;
    check("fetch_rst_empty", empty, 1);
    check("fetch_rst_ready", cpu_wr_ready, 1);
    check("fetch_rst_addrb", bram_addrb, 0);
    repeat (15) tick();
    check("fetch_rst_no_start", 32'(out_q.size()), 0);
    cpu_wr_valid = 1'b1;
    cpu_wr_data  = 8'h5A;
    m = cyc;
    tick();
    cpu_wr_valid = 1'b0;
    check("fetch_rst_addra", bram_addra, 0);
    wait_out(1, "fetch_rst");
    check("fetch_rst_data", out_q[0], 8'h5A);
    check("fetch_rst_cycle", 32'(out_cyc[0]), 32'(m + 6));

    // Random pushes and busy lengths against an in-order occupancy model.
    do_reset();
    rand_len = 1'b1;
    exp_q.delete();
    acc = 0;
    for (int t = 0; t < 400; t++) begin
      diff = acc - out_q.size();
      if (diff <= 6) check("rnd_ready_room", cpu_wr_ready, 1);
      else if (diff >= 8) check("rnd_ready_full", cpu_wr_ready, 0);
      v = ($urandom_range(0, 99) < 60);
      cpu_wr_valid = v;
      cpu_wr_data  = 8'($urandom);
      if (v && cpu_wr_ready) begin
        exp_q.push_back(cpu_wr_data);
        acc++;
      end
      tick();
    end
    cpu_wr_valid = 1'b0;
    wait_out(acc, "rnd");
    for (int i = 0; i < acc; i++) check($sformatf("rnd_byte_%0d", i), out_q[i], exp_q[i]);
    repeat (10) tick();
    check("rnd_empty_end", empty, 1);
    check("protocol_violations", 32'(proto_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
